// File: rtl/fft_mag_sq.sv
// fft_mag_sq: squared magnitude (re*re + im*im) of streaming FFT output
// samples, with window framing (mag_last) and a framing-mismatch flag
// (frame_err). The datapath is a fixed 3-stage pipeline with no backpressure.
// Optional feature: define FFT_MAG_DC_BLOCK_EN to force the DC bin (window
// index 0) to mag=0 without changing latency or framing.
module fft_mag_sq #(
    parameter int NSamples = 1024,
    parameter int WIn      = 16,
    parameter int W        = 33,
    parameter int NBits    = $clog2(NSamples)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [WIn-1:0] re,
    input  logic signed [WIn-1:0] im,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic [W-1:0]          mag,
    output logic                  mag_valid,
    output logic                  mag_last,
    output logic                  frame_err
);

    localparam logic [NBits-1:0] LastIdx = NBits'(NSamples - 1);

    // Square of a signed sample. The largest result, (-2^(WIn-1))^2 =
    // 2^(2*WIn-2), fits in 2*WIn bits, so the product is reinterpreted
    // as unsigned without loss.
    function automatic logic [2*WIn-1:0] square_u(input logic signed [WIn-1:0] x);
        logic signed [2*WIn-1:0] xe;
        logic signed [2*WIn-1:0] p;
        xe = {{WIn{x[WIn-1]}}, x};
        p  = xe * xe;
        return unsigned'(p);
    endfunction

    // Sum of two squares, zero-extended to the output width. Each square is
    // at most 2^(2*WIn-2), so the sum (at most 2^(2*WIn-1)) fits in 2*WIn bits.
    function automatic logic [W-1:0] sum_zext(input logic [2*WIn-1:0] a,
                                              input logic [2*WIn-1:0] b);
        logic [2*WIn-1:0] s;
        s = a + b;
        return W'(s);
    endfunction

    logic [NBits-1:0] cnt;
    logic             cnt_at_end;

    logic signed [WIn-1:0] re_p0, im_p0;
    logic                  vld_p0, last_p0, err_p0;

    logic [2*WIn-1:0] sq_re_p1, sq_im_p1;
    logic             vld_p1, last_p1, err_p1;

    logic [W-1:0] mag_p2;
    logic         vld_p2, last_p2, err_p2;

    assign cnt_at_end = (cnt == LastIdx);

    // Window sample counter; wraps at the window end and resynchronises to 0
    // on any accepted in_last, whether or not it arrived at the expected index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (in_valid) begin
            if (in_last || cnt_at_end)
                cnt <= '0;
            else
                cnt <= cnt + NBits'(1);
        end
    end

    // ---- Stage 1: capture sample and its framing flags ----

    // Stage 1 control: valid, window-end and framing-error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            err_p0  <= 1'b0;
        end else begin
            vld_p0  <= in_valid;
            last_p0 <= in_last | cnt_at_end;
            err_p0  <= in_last & ~cnt_at_end;
        end
    end

    // Stage 1 data: input sample registers (qualified by vld_p0 downstream).
    always_ff @(posedge clk) begin
        if (in_valid) begin
            re_p0 <= re;
            im_p0 <= im;
        end
    end

`ifdef FFT_MAG_DC_BLOCK_EN
    logic dc_p0;

    // Marks the DC bin (window index 0) so its squares can be zeroed.
    always_ff @(posedge clk) begin
        if (in_valid)
            dc_p0 <= (cnt == '0);
    end
`endif

    // ---- Stage 2: squares ----

    // Stage 2 control: forward valid and framing flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            err_p1  <= err_p0;
        end
    end

    // Stage 2 data: square both components (DC bin forced to zero if enabled).
    always_ff @(posedge clk) begin
        if (vld_p0) begin
`ifdef FFT_MAG_DC_BLOCK_EN
            sq_re_p1 <= dc_p0 ? '0 : square_u(re_p0);
            sq_im_p1 <= dc_p0 ? '0 : square_u(im_p0);
`else
            sq_re_p1 <= square_u(re_p0);
            sq_im_p1 <= square_u(im_p0);
`endif
        end
    end

    // ---- Stage 3: sum and output registers ----

    // Stage 3: outputs update only on a valid sample and hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            mag_p2  <= '0;
            last_p2 <= 1'b0;
            err_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mag_p2  <= sum_zext(sq_re_p1, sq_im_p1);
                last_p2 <= last_p1;
                err_p2  <= err_p1;
            end
        end
    end

    assign mag       = mag_p2;
    assign mag_valid = vld_p2;
    assign mag_last  = last_p2;
    assign frame_err = err_p2;

endmodule

// File: doc/fft_mag_sq.md
FFT_MAG_SQ -- requirements
Module: fft_mag_sq

Interface
REQ-001 Parameter NSamples, default 1024: FFT window length in samples; power of two.
REQ-002 Parameter WIn, default 16: width of the signed real and imaginary inputs.
REQ-003 Parameter W, default 33: width of the magnitude output; SHALL satisfy W >= 2*WIn.
REQ-004 Parameter NBits, default $clog2(NSamples): width of the sample index.
REQ-005 Port clk, input, 1: the only clock; all logic rising-edge.
REQ-006 Port reset, input, 1: synchronous, active-low reset.
REQ-007 Port re, input, WIn: signed real part of the FFT output sample.
REQ-008 Port im, input, WIn: signed imaginary part of the FFT output sample.
REQ-009 Port in_valid, input, 1: re, im and in_last are valid this cycle.
REQ-010 Port in_last, input, 1: upstream end-of-window marker; only meaningful with in_valid.
REQ-011 Port mag, output, W: unsigned re*re + im*im, zero-extended to W bits.
REQ-012 Port mag_valid, output, 1: mag is valid this cycle; feeds the peak finder's mag_valid.
REQ-013 Port mag_last, output, 1: mag is the last sample of a window.
REQ-014 Port frame_err, output, 1: one-cycle pulse on window framing mismatch.

Function
REQ-015 The block SHALL have no backpressure and SHALL accept every cycle in which in_valid=1.
REQ-016 The datapath SHALL be a fixed 3-stage pipeline: S1 registers re, im, valid and last; S2 registers re*re and im*im (each unsigned, 2*WIn bits); S3 registers their sum, zero-extended to W.
REQ-017 mag_valid SHALL follow in_valid by exactly 3 cycles, with in_valid gaps reproduced as equal gaps.
REQ-018 The sum SHALL NOT overflow: worst case re=im=-2^(WIn-1) gives 2^(2*WIn-1), which fits in W bits.
REQ-019 A sample counter cnt (NBits) SHALL be 0 after reset and SHALL increment on each accepted sample, wrapping from NSamples-1 to 0.
REQ-020 mag_last SHALL be 1 on the output of the sample accepted when cnt==NSamples-1, or when in_last=1, and 0 otherwise.
REQ-021 If an accepted sample has in_last=1 and cnt!=NSamples-1, frame_err SHALL pulse aligned with that sample's output, and cnt SHALL resynchronise to 0 on the next cycle.
REQ-022 If cnt==NSamples-1 and in_last=0, the window SHALL still close (mag_last=1) and frame_err SHALL NOT assert; in_last is a check, not a requirement.
REQ-023 mag, mag_last and frame_err SHALL hold their last values while mag_valid=0; a consumer SHALL qualify them with mag_valid.

Reset
REQ-024 While reset=0 at a rising edge, all pipeline valid bits SHALL clear, cnt SHALL go to 0, and mag, mag_valid, mag_last and frame_err SHALL go to 0.
REQ-025 Reset asserted mid-window SHALL discard all in-flight samples; the first sample accepted after reset release is index 0 of a new window.
REQ-026 mag_valid SHALL stay 0 for at least 3 cycles after reset release regardless of in_valid.

Configuration
REQ-027 Macro FFT_MAG_DC_BLOCK_EN: when defined, the output for window index 0 (DC bin) SHALL be forced to mag=0, with mag_valid asserted as normal; when undefined, index 0 is computed like any other sample.
REQ-028 Latency, framing and frame_err behaviour SHALL be identical with and without FFT_MAG_DC_BLOCK_EN.

Verification
REQ-029 re=3, im=-4, one valid cycle -> 3 cycles later mag=25, mag_valid=1 for exactly one cycle.
REQ-030 re=im=-32768 (WIn=16) -> mag=2147483648, with no sign extension into bit 32.
REQ-031 1024 contiguous valid samples with in_last only on the last -> mag_last=1 only on output #1023 and frame_err never asserts; a second window behaves identically.
REQ-032 in_last=1 on sample #500 -> mag_last=1 and frame_err=1 on output #500; the next sample is counted as index 0.
REQ-033 Valid pattern 1,0,0,1,1 -> output valid pattern 1,0,0,1,1 delayed by 3 cycles; reset=0 asserted while 2 samples are in flight -> neither appears and cnt restarts at 0.
REQ-034 With FFT_MAG_DC_BLOCK_EN defined: window sample 0 with re=100, im=0 -> mag=0; sample 1 with re=100, im=0 -> mag=10000.
